// File: rtl/wspr_cfg_pkg.sv
// Shared definitions for the tinywspr configuration link: byte width, default strobe
// timing and the transmitter FSM state encoding.
package wspr_cfg_pkg;

    localparam int unsigned CFG_W = 8;

    // The receiver runs cfg_valid through a 2-FF synchronizer plus an edge detector.
    localparam int unsigned SyncStages       = 2;
    localparam int unsigned DefCfgBytes      = 16;
    localparam int unsigned DefLeadCycles    = 8;
    localparam int unsigned DefSetupCycles   = SyncStages + 2;
    localparam int unsigned DefHighCycles    = SyncStages + 2;
    localparam int unsigned DefLowCycles     = SyncStages + 2;
    localparam int unsigned DefFifoDepth     = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StFetch,
        StSetup,
        StHigh,
        StLow,
        StDone
    } state_e;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/wspr_config_tx_if.sv
// Host stream, frame control and receiver-facing pins of the config transmitter.
interface wspr_config_tx_if;
    import wspr_cfg_pkg::*;

    logic [CFG_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             go;
    logic             stop;
    logic             busy;
    logic             done;
    logic [CFG_W-1:0] cfg_bits;
    logic             cfg_valid;
    logic             cfg_start;
    logic             rf_start;

    modport master (
        output in_data, in_valid, go, stop,
        input  in_ready, busy, done, cfg_bits, cfg_valid, cfg_start, rf_start
    );

    modport slave (
        input  in_data, in_valid, go, stop,
        output in_ready, busy, done, cfg_bits, cfg_valid, cfg_start, rf_start
    );

endinterface

// File: rtl/wspr_byte_fifo.sv
// Small synchronous first-word-fall-through FIFO with a synchronous flush.
module wspr_byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wspr_config_tx.sv
// Config frame transmitter: buffers host bytes and presents each one on the 8-bit bus with a
// slow valid strobe, framed by cfg_start, then raises rf_start once the frame is complete.
module wspr_config_tx
    import wspr_cfg_pkg::*;
#(
    parameter int unsigned CFG_BYTES    = DefCfgBytes,
    parameter int unsigned LEAD_CYCLES  = DefLeadCycles,
    parameter int unsigned SETUP_CYCLES = DefSetupCycles,
    parameter int unsigned HIGH_CYCLES  = DefHighCycles,
    parameter int unsigned LOW_CYCLES   = DefLowCycles,
    parameter int unsigned FIFO_DEPTH   = DefFifoDepth
) (
    input logic             clock,
    input logic             reset,
    wspr_config_tx_if.slave bus
);
    localparam int unsigned TmrMax = max4(LEAD_CYCLES, SETUP_CYCLES, HIGH_CYCLES, LOW_CYCLES);
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam int unsigned CntW   = $clog2(CFG_BYTES + 1);

    state_e           state_q, state_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic [CntW-1:0]  sent_q, sent_d;
    logic [CFG_W-1:0] bits_q, bits_d;
    logic             done_q, done_d;
    logic             cfg_valid_q, cfg_start_q, rf_start_q;

    logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [CFG_W-1:0] fifo_rdata;
    logic             tmr_zero;

    assign fifo_push = bus.in_valid && !fifo_full;
    assign tmr_zero  = (tmr_q == '0);

    wspr_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CFG_W)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (bus.in_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        sent_d     = sent_q;
        bits_d     = bits_q;
        done_d     = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (bus.stop) begin
            state_d    = StIdle;
            tmr_d      = '0;
            sent_d     = '0;
            fifo_flush = 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.go) begin
                        state_d = StLead;
                        tmr_d   = TmrW'(LEAD_CYCLES - 1);
                        sent_d  = '0;
                    end
                end
                StLead: begin
                    if (tmr_zero) state_d = StFetch;
                    else          tmr_d   = tmr_q - TmrW'(1);
                end
                // No timeout: a slow source simply holds the frame open here.
                StFetch: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        bits_d   = fifo_rdata;
                        state_d  = StSetup;
                        tmr_d    = TmrW'(SETUP_CYCLES - 1);
                    end
                end
                StSetup: begin
                    if (tmr_zero) begin
                        state_d = StHigh;
                        tmr_d   = TmrW'(HIGH_CYCLES - 1);
                    end else begin
                        tmr_d = tmr_q - TmrW'(1);
                    end
                end
                StHigh: begin
                    if (tmr_zero) begin
                        state_d = StLow;
                        tmr_d   = TmrW'(LOW_CYCLES - 1);
                        sent_d  = sent_q + CntW'(1);
                    end else begin
                        tmr_d = tmr_q - TmrW'(1);
                    end
                end
                StLow: begin
                    if (!tmr_zero) begin
                        tmr_d = tmr_q - TmrW'(1);
                    end else if (sent_q < CntW'(CFG_BYTES)) begin
                        state_d = StFetch;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Pin-facing outputs are decoded from the next state and registered so they never glitch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            tmr_q       <= '0;
            sent_q      <= '0;
            bits_q      <= '0;
            done_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_start_q <= 1'b0;
            rf_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            sent_q      <= sent_d;
            bits_q      <= bits_d;
            done_q      <= done_d;
            cfg_valid_q <= (state_d == StHigh);
            cfg_start_q <= (state_d inside {StLead, StFetch, StSetup, StHigh, StLow});
            rf_start_q  <= (state_d == StDone);
        end
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.busy      = (state_q != StIdle) && (state_q != StDone);
    assign bus.done      = done_q;
    assign bus.cfg_bits  = bits_q;
    assign bus.cfg_valid = cfg_valid_q;
    assign bus.cfg_start = cfg_start_q;
    assign bus.rf_start  = rf_start_q;

endmodule

// File: tb/tb_wspr_config_tx.sv
// Directed bench for wspr_config_tx: a modelled receiver (2-FF sync + rising edge) pops the
// scoreboard of pushed bytes, while the main sequence checks framing, stalls, stop and reset.
module tb_wspr_config_tx;
    import wspr_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   rx_cnt    = 0;
    int   vrise_cnt = 0;
    int   done_cnt  = 0;

    logic [CFG_W-1:0] sb [$];
    logic [CFG_W-1:0] rx_exp;
    logic [2:0]       sync_q     = '0;
    logic             prev_valid = 1'b0;
    logic [CFG_W-1:0] prev_bits  = '0;

    wspr_config_tx_if ifc ();

    wspr_config_tx dut (
        .clock (clk),
        .reset (rst),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Receiver model and pin-level monitors, all sampled on the falling edge.
    always @(negedge clk) begin
        sync_q     <= {sync_q[1:0], ifc.cfg_valid};
        prev_valid <= ifc.cfg_valid;
        prev_bits  <= ifc.cfg_bits;
        if (ifc.cfg_valid && !prev_valid) vrise_cnt <= vrise_cnt + 1;
        if (ifc.done) done_cnt <= done_cnt + 1;

        checks++;
        assert (!ifc.cfg_valid || ifc.cfg_start) else begin
            failures++;
            $error("FAIL valid_without_start observed start=%0b required=1", ifc.cfg_start);
        end
        checks++;
        assert (!((ifc.cfg_bits !== prev_bits) && (ifc.cfg_valid || prev_valid))) else begin
            failures++;
            $error("FAIL bits_stable observed=0x%0h required=0x%0h", ifc.cfg_bits, prev_bits);
        end

        if (sync_q[1] && !sync_q[2]) begin
            rx_cnt <= rx_cnt + 1;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $error("FAIL rx_byte observed=0x%0h required=none", ifc.cfg_bits);
            end else begin
                rx_exp = sb.pop_front();
                assert (ifc.cfg_bits === rx_exp) else begin
                    failures++;
                    $error("FAIL rx_byte observed=0x%0h required=0x%0h", ifc.cfg_bits, rx_exp);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({ifc.in_ready, ifc.busy, ifc.done, ifc.cfg_valid, ifc.cfg_start,
                    ifc.rf_start, ifc.cfg_bits});
    endfunction

    function automatic int cnt(input int which);
        case (which)
            0:       return rx_cnt;
            1:       return vrise_cnt;
            default: return done_cnt;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int max_cyc,
                            input string tag);
        int n = 0;
        while (cnt(which) < target && n < max_cyc) begin
            step(1);
            n++;
        end
        check(tag, 32'(cnt(which) >= target), 32'd1);
    endtask

    task automatic push_byte(input logic [CFG_W-1:0] b);
        int n = 0;
        while (!ifc.in_ready && n < 2000) begin
            step(1);
            n++;
        end
        check("push_ready", 32'(ifc.in_ready), 32'd1);
        if (ifc.in_ready) begin
            ifc.in_data  = b;
            ifc.in_valid = 1'b1;
            sb.push_back(b);
            step(1);
            ifc.in_valid = 1'b0;
        end
    endtask

    task automatic pulse_go();
        ifc.go = 1'b1;
        step(1);
        ifc.go = 1'b0;
    endtask

    initial begin
        int b_rx, b_vr, b_dn, n;
        ifc.in_data  = '0;
        ifc.in_valid = 1'b0;
        ifc.go       = 1'b0;
        ifc.stop     = 1'b0;

        step(3);
        check("reset_outs", outs(), 32'h2000);
        rst = 1'b0;
        step(1);
        check("idle_outs", outs(), 32'h2000);

        // Frame 1: bytes 0x00..0x0F, back-to-back source.
        b_rx = rx_cnt; b_vr = vrise_cnt; b_dn = done_cnt;
        for (int i = 0; i < 4; i++) push_byte(8'(i));
        check("fifo_full_ready", 32'(ifc.in_ready), 32'd0);
        pulse_go();
        check("lead_state", 32'({ifc.busy, ifc.cfg_start, ifc.cfg_valid}), 32'h6);
        for (int i = 4; i < 16; i++) push_byte(8'(i));
        wait_for(2, b_dn + 1, 3000, "frame1_done");
        check("frame1_done_state", 32'({ifc.rf_start, ifc.cfg_start, ifc.busy}), 32'h4);
        step(5);
        check("frame1_done_once", 32'(done_cnt - b_dn), 32'd1);
        check("frame1_done_low", 32'(ifc.done), 32'd0);
        check("frame1_rx", 32'(rx_cnt - b_rx), 32'd16);
        check("frame1_rises", 32'(vrise_cnt - b_vr), 32'd16);
        check("frame1_sb_empty", 32'(sb.size()), 32'd0);

        // Frame 2: go from DONE, slow source stalls FETCH, go during LOW is ignored.
        b_rx = rx_cnt; b_vr = vrise_cnt; b_dn = done_cnt;
        pulse_go();
        check("go_done_rf_drop", 32'({ifc.rf_start, ifc.busy, ifc.cfg_start}), 32'h3);
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(8'h10 + i));
            if (i == 2) begin
                n = 0;
                while (!ifc.cfg_valid && n < 100) begin step(1); n++; end
                while (ifc.cfg_valid && n < 100) begin step(1); n++; end
                check("reach_low", 32'(n < 100), 32'd1);
                pulse_go();
                check("go_in_low_ignored", 32'({ifc.busy, ifc.cfg_start}), 32'h3);
                step(20);
            end else if (i < 15) begin
                step(38);
            end
            if (i < 15) begin
                check("stall_fetch", 32'({ifc.busy, ifc.cfg_start, ifc.cfg_valid}), 32'h6);
                check("no_early_done", 32'(done_cnt - b_dn), 32'd0);
            end
        end
        wait_for(2, b_dn + 1, 500, "frame2_done");
        step(3);
        check("frame2_rx", 32'(rx_cnt - b_rx), 32'd16);
        check("frame2_rises", 32'(vrise_cnt - b_vr), 32'd16);
        check("frame2_rf", 32'(ifc.rf_start), 32'd1);

        // Frame 3: stop during HIGH of byte 5 with the FIFO still holding bytes.
        b_rx = rx_cnt; b_vr = vrise_cnt; b_dn = done_cnt;
        for (int i = 0; i < 4; i++) push_byte(8'(8'h20 + i));
        pulse_go();
        for (int i = 4; i < 9; i++) push_byte(8'(8'h20 + i));
        wait_for(1, b_vr + 5, 200, "byte5_high");
        ifc.stop = 1'b1;
        step(1);
        ifc.stop = 1'b0;
        check("stop_outs", outs(), 32'h2024);
        step(6);
        check("stop_rx", 32'(rx_cnt - b_rx), 32'd5);
        check("stop_no_done", 32'(done_cnt - b_dn), 32'd0);
        sb.delete();

        // go and stop together in IDLE: stop wins.
        ifc.go   = 1'b1;
        ifc.stop = 1'b1;
        step(1);
        ifc.go   = 1'b0;
        ifc.stop = 1'b0;
        check("go_stop_idle", outs(), 32'h2024);
        step(10);
        check("still_idle", 32'(ifc.busy), 32'd0);

        // Flushed FIFO: a new frame must stall with nothing to send.
        b_vr = vrise_cnt;
        pulse_go();
        step(30);
        check("flush_stall", 32'({ifc.busy, ifc.cfg_start, ifc.cfg_valid}), 32'h6);
        check("flush_no_rise", 32'(vrise_cnt - b_vr), 32'd0);

        // Reset in SETUP of the second byte of this frame.
        b_rx = rx_cnt;
        push_byte(8'hA5);
        push_byte(8'h5A);
        push_byte(8'h33);
        push_byte(8'h44);
        wait_for(0, b_rx + 1, 200, "rx_a5");
        n = 0;
        while (ifc.cfg_bits !== 8'h5A && n < 100) begin step(1); n++; end
        check("reach_setup", 32'(ifc.cfg_bits), 32'h5A);
        check("setup_valid_low", 32'(ifc.cfg_valid), 32'd0);
        rst = 1'b1;
        step(1);
        check("midframe_reset_outs", outs(), 32'h2000);
        rst = 1'b0;
        sb.delete();
        b_vr = vrise_cnt;
        pulse_go();
        step(30);
        check("reset_fifo_empty", 32'(vrise_cnt - b_vr), 32'd0);
        check("reset_ready", 32'(ifc.in_ready), 32'd1);
        ifc.stop = 1'b1;
        step(1);
        ifc.stop = 1'b0;
        step(1);
        check("final_idle", outs(), 32'h2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog observed=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
